// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package div_pkg;

    localparam int DIV_W = 32;
    localparam int DIV_ITER = 32;
    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/addsub33.sv
// 33-bit adder/subtractor: sub=1 computes x + ~y + 1, with carry out.
module addsub33 (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [32:0] y_eff;

    assign y_eff = sub ? ~y : y;
    assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {33'd0, sub};

endmodule

// File: rtl/div32_seq.sv
// Iterative non-restoring 32-bit divider, one quotient bit per cycle.
// Optional signed mode is built when DIV_SIGNED_EN is defined.
import div_pkg::*;

module div32_seq #(
    parameter int W     = DIV_W,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sign,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [W:0]       pr;
    logic [W-1:0]     qr;
    logic [W-1:0]     dv;
    logic             zdiv;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic             neg_q_in;
    logic             neg_r_in;
    logic             neg_q;
    logic             neg_r;

    logic [W:0]   as_x;
    logic [W:0]   as_y;
    logic         as_sub;
    logic [W:0]   as_sum;
    logic         unused_cout;
    logic [W-1:0] r_fix;

    assign zdiv = (b == '0);

`ifdef DIV_SIGNED_EN
    // zero divisor keeps the raw dividend so r reports a unchanged
    assign a_mag = (sign & a[W-1] & ~zdiv) ? (~a + 1'b1) : a;
    assign b_mag = (sign & b[W-1]) ? (~b + 1'b1) : b;
    assign neg_q_in = sign & (a[W-1] ^ b[W-1]) & ~zdiv;
    assign neg_r_in = sign & a[W-1] & ~zdiv;
`else
    logic unused_sign;
    assign unused_sign = sign;
    assign a_mag = a;
    assign b_mag = b;
    assign neg_q_in = 1'b0;
    assign neg_r_in = 1'b0;
`endif

    assign as_x   = (state == FIX) ? pr : {pr[W-1:0], qr[W-1]};
    assign as_y   = {1'b0, dv};
    assign as_sub = (state == RUN) & ~pr[W];

    addsub33 u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (unused_cout)
    );

    assign r_fix = pr[W] ? as_sum[W-1:0] : pr[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // zero divisor spends its single busy cycle in FIX so done lands in cycle 2
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = zdiv ? FIX : RUN;
            RUN:  if (cnt == CNT_W'(W - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) | (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pr    <= '0;
            qr    <= '0;
            dv    <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        pr    <= '0;
                        qr    <= a_mag;
                        dv    <= b_mag;
                        dz    <= zdiv;
                        neg_q <= neg_q_in;
                        neg_r <= neg_r_in;
                    end
                end
                RUN: begin
                    pr  <= as_sum;
                    qr  <= {qr[W-2:0], ~as_sum[W]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (dz) begin
                        q <= DZ_QUOT;
                        r <= qr;
                    end else begin
                        q <= neg_q ? (~qr + 1'b1) : qr;
                        r <= neg_r ? (~r_fix + 1'b1) : r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq.
module tb_div32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dz;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs [$];

    div32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // returns cycle index of done (start sampled in cycle 0) and busy count
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           input logic sg, output int lat, output int nbusy);
        @(negedge clk);
        a = av;
        b = bv;
        sign = sg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic add_vec(input logic [31:0] av, input logic [31:0] bv,
                           input logic sg, input logic [31:0] qv,
                           input logic [31:0] rv, input logic dzv,
                           input int lv);
        vec_t v;
        v.a = av; v.b = bv; v.sg = sg;
        v.q = qv; v.r = rv; v.dz = dzv; v.lat = lv;
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        int nbusy;
        int cyc;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        sign = 1'b0;
        a = '0;
        b = '0;

        add_vec(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
        add_vec(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
        add_vec(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 34);
        add_vec(32'd123, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd123, 1'b1, 2);
        add_vec(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 34);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34);
        add_vec(32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2, 1'b0, 34);
        add_vec(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 34);
        add_vec(32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0, 34);
        add_vec(32'hFFFF_FFFE, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFE,
                1'b0, 34);
`ifdef DIV_SIGNED_EN
        add_vec(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                1'b0, 34);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,
                1'b0, 34);
        add_vec(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
`endif

        repeat (2) @(negedge clk);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sg, lat, nbusy);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(nbusy), 32'(vecs[i].lat - 1));
            chk($sformatf("v%0d_q", i), q, vecs[i].q);
            chk($sformatf("v%0d_r", i), r, vecs[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
        end

        // second start mid-divide must be dropped
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        sign = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_lat", 32'(cyc), 32'd34);
        chk("ign_q", q, 32'd14);
        chk("ign_r", r, 32'd2);

        // start coinciding with done is dropped; the next cycle accepts it
        a = 32'd50;
        b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        chk("done_start_q", q, 32'd14);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("w3_busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("w3_lat", 32'(cyc), 32'd34);
        chk("w3_q", q, 32'd10);
        chk("w3_r", r, 32'd0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(negedge clk);
            cyc++;
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q", q, 32'd0);
        chk("mid_rst_r", r, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd100, 32'd7, 1'b0, lat, nbusy);
        chk("post_rst_lat", 32'(lat), 32'd34);
        chk("post_rst_q", q, 32'd14);
        chk("post_rst_r", r, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
